bus_fifo_bank: RTL and testbench

Parametrised bank of per-driver FIFOs that sits between the sequencer/agent side of the bus-driver test environment and the `bs_gnrtr_n_rbtr` bus DUT. It replaces the hand-wired per-driver `pndng`/`pop`/`D_pop` interfaces with real storage. Each of `DRVS` channels is an independent circular FIFO:

- The agent writes packets in.
- The bus DUT drains them through the standard pending/pop handshake with show-ahead data.
- Per-channel occupancy, full, overflow and underflow status are reported.

---
 rtl/bus_fifo_bank.sv | 97 +++++++++
 tb/tb_bus_fifo_bank.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_fifo_bank.sv
// Bank of DRVS independent circular FIFOs with a show-ahead pending/pop drain side.
// Build option: define FIFO_OVERWRITE_EN so that a write to a full channel replaces its oldest entry.
module bus_fifo_bank #(
    parameter int WIDTH = 16,
    parameter int DRVS  = 8,
    parameter int DEPTH = 8,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DRVS-1:0]       wr_en,
    input  logic [DRVS*WIDTH-1:0] wr_data,
    output logic [DRVS-1:0]       full,
    output logic [DRVS-1:0]       pndng,
    input  logic [DRVS-1:0]       pop,
    output logic [DRVS*WIDTH-1:0] D_pop,
    output logic [DRVS*CW-1:0]    count,
    output logic [DRVS-1:0]       ovf,
    output logic [DRVS-1:0]       udf
);

    localparam int PW = $clog2(DEPTH);

`ifdef FIFO_OVERWRITE_EN
    localparam bit OVERWRITE = 1'b1;
`else
    localparam bit OVERWRITE = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < DRVS; gi++) begin : g_ch
            logic [WIDTH-1:0] mem_reg [DEPTH];
            logic [PW-1:0]    wr_ptr_reg;
            logic [PW-1:0]    rd_ptr_reg;
            logic [CW-1:0]    count_reg;
            logic [CW-1:0]    count_next;
            logic             ovf_reg;
            logic             udf_reg;
            logic             is_full;
            logic             is_empty;
            logic             pop_acc;
            logic             wr_acc;
            logic             ovw;
            logic             rd_adv;

            // A pop at full frees a slot in the same cycle, so the write lands there.
            always_comb begin
                is_full    = (count_reg == CW'(DEPTH));
                is_empty   = (count_reg == '0);
                pop_acc    = pop[gi] && !is_empty;
                ovw        = OVERWRITE && wr_en[gi] && is_full && !pop[gi];
                wr_acc     = wr_en[gi] && (!is_full || pop[gi] || OVERWRITE);
                rd_adv     = pop_acc || ovw;
                count_next = count_reg;
                if (wr_acc && !rd_adv)
                    count_next = count_reg + CW'(1);
                else if (!wr_acc && rd_adv)
                    count_next = count_reg - CW'(1);
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                    ovf_reg    <= 1'b0;
                    udf_reg    <= 1'b0;
                end else begin
                    if (wr_acc)
                        wr_ptr_reg <= wr_ptr_reg + PW'(1);
                    if (rd_adv)
                        rd_ptr_reg <= rd_ptr_reg + PW'(1);
                    count_reg <= count_next;
                    if (wr_en[gi] && is_full && !pop[gi])
                        ovf_reg <= 1'b1;
                    if (pop[gi] && is_empty)
                        udf_reg <= 1'b1;
                end
            end

            // Storage is deliberately left uncleared by reset; only writes during reset are blocked.
            always_ff @(posedge clk) begin
                if (!reset && wr_acc)
                    mem_reg[wr_ptr_reg] <= wr_data[gi*WIDTH +: WIDTH];
            end

            assign pndng[gi]                = !is_empty;
            assign full[gi]                 = is_full;
            assign count[gi*CW +: CW]       = count_reg;
            assign ovf[gi]                  = ovf_reg;
            assign udf[gi]                  = udf_reg;
            assign D_pop[gi*WIDTH +: WIDTH] = is_empty ? '0 : mem_reg[rd_ptr_reg];
        end
    endgenerate

endmodule

// File: tb/tb_bus_fifo_bank.sv
// Directed plus randomized checks of bus_fifo_bank against a queue-based reference model.
module tb_bus_fifo_bank;
    localparam int WIDTH = 16;
    localparam int DRVS  = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

`ifdef FIFO_OVERWRITE_EN
    localparam bit OVW = 1'b1;
`else
    localparam bit OVW = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic [DRVS-1:0]       wr_en;
    logic [DRVS*WIDTH-1:0] wr_data;
    logic [DRVS-1:0]       full;
    logic [DRVS-1:0]       pndng;
    logic [DRVS-1:0]       pop;
    logic [DRVS*WIDTH-1:0] D_pop;
    logic [DRVS*CW-1:0]    count;
    logic [DRVS-1:0]       ovf;
    logic [DRVS-1:0]       udf;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] mq [DRVS][$];
    bit               movf [DRVS];
    bit               mudf [DRVS];

    bus_fifo_bank #(.WIDTH(WIDTH), .DRVS(DRVS), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full),
        .pndng(pndng), .pop(pop), .D_pop(D_pop), .count(count), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    function automatic logic [DRVS-1:0] bit_of(input int ch);
        bit_of = DRVS'(1) << ch;
    endfunction

    function automatic logic [DRVS*WIDTH-1:0] put(input int ch, input logic [WIDTH-1:0] v);
        put = '0;
        put[ch*WIDTH +: WIDTH] = v;
    endfunction

    // Reference behaviour: a queue per channel plus sticky flags.
    task automatic model_step(input logic rst, input logic [DRVS-1:0] w, input logic [DRVS-1:0] p,
                              input logic [DRVS*WIDTH-1:0] d);
        int n;
        for (int i = 0; i < DRVS; i++) begin
            n = mq[i].size();
            if (rst) begin
                mq[i].delete();
                movf[i] = 1'b0;
                mudf[i] = 1'b0;
            end else begin
                if (p[i] && n == 0) mudf[i] = 1'b1;
                if (p[i] && n != 0) void'(mq[i].pop_front());
                if (w[i]) begin
                    if (n < DEPTH || p[i]) begin
                        mq[i].push_back(d[i*WIDTH +: WIDTH]);
                    end else begin
                        movf[i] = 1'b1;
                        if (OVW) begin
                            void'(mq[i].pop_front());
                            mq[i].push_back(d[i*WIDTH +: WIDTH]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [DRVS-1:0]       e_p, e_f, e_o, e_u;
        logic [DRVS*WIDTH-1:0] e_d;
        logic [DRVS*CW-1:0]    e_c;
        for (int i = 0; i < DRVS; i++) begin
            e_p[i] = (mq[i].size() != 0);
            e_f[i] = (mq[i].size() == DEPTH);
            e_c[i*CW +: CW] = CW'(mq[i].size());
            e_d[i*WIDTH +: WIDTH] = (mq[i].size() != 0) ? mq[i][0] : '0;
            e_o[i] = movf[i];
            e_u[i] = mudf[i];
        end
        checks++;
        assert (pndng === e_p) else begin errors++; $error("FAIL %s pndng: got %h expected %h", tag, pndng, e_p); end
        checks++;
        assert (full === e_f) else begin errors++; $error("FAIL %s full: got %h expected %h", tag, full, e_f); end
        checks++;
        assert (count === e_c) else begin errors++; $error("FAIL %s count: got %h expected %h", tag, count, e_c); end
        checks++;
        assert (D_pop === e_d) else begin errors++; $error("FAIL %s D_pop: got %h expected %h", tag, D_pop, e_d); end
        checks++;
        assert (ovf === e_o) else begin errors++; $error("FAIL %s ovf: got %h expected %h", tag, ovf, e_o); end
        checks++;
        assert (udf === e_u) else begin errors++; $error("FAIL %s udf: got %h expected %h", tag, udf, e_u); end
    endtask

    task automatic step(input string tag, input logic rst, input logic [DRVS-1:0] w,
                        input logic [DRVS-1:0] p, input logic [DRVS*WIDTH-1:0] d);
        reset   = rst;
        wr_en   = w;
        pop     = p;
        wr_data = d;
        @(posedge clk);
        model_step(rst, w, p, d);
        #1;
        $display("txn %s rst=%0b wr=%b pop=%b", tag, rst, w, p);
        check_all(tag);
    endtask

    initial begin
        logic [DRVS*WIDTH-1:0] rd;
        logic [DRVS-1:0]       rw, rp;
        logic [WIDTH-1:0]      exp_v;

        reset = 1'b1; wr_en = '0; pop = '0; wr_data = '0;

        // Reset with writes requested on every channel
        step("rst0", 1'b1, '1, '0, {DRVS{16'h5A5A}});
        step("rst1", 1'b1, '1, '0, {DRVS{16'h5A5A}});
        step("idle", 1'b0, '0, '0, '0);
        chk("rst_pndng", 32'(pndng), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_dpop", 32'(D_pop[WIDTH-1:0]), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_udf", 32'(udf), 0);

        // FIFO order on channel 3
        for (int k = 1; k <= 4; k++) step("ord_wr", 1'b0, bit_of(3), '0, put(3, WIDTH'(k)));
        for (int k = 1; k <= 4; k++) begin
            chk("ord_head", 32'(D_pop[3*WIDTH +: WIDTH]), k);
            step("ord_pop", 1'b0, '0, bit_of(3), '0);
        end
        chk("ord_pndng", 32'(pndng[3]), 0);

        // Overflow on channel 0
        for (int k = 0; k < 9; k++) step("ovf_wr", 1'b0, bit_of(0), '0, put(0, WIDTH'(16'hA0 + k)));
        chk("ovf_full", 32'(full[0]), 1);
        chk("ovf_count", 32'(count[0 +: CW]), 8);
        chk("ovf_flag", 32'(ovf[0]), 1);
        for (int k = 0; k < 8; k++) begin
            chk("ovf_drain", 32'(D_pop[0 +: WIDTH]), OVW ? 32'(16'hA1 + k) : 32'(16'hA0 + k));
            step("ovf_pop", 1'b0, '0, bit_of(0), '0);
        end

        // Simultaneous write and pop at full on channel 5
        for (int k = 0; k < 8; k++) step("sim_wr", 1'b0, bit_of(5), '0, put(5, WIDTH'(16'h50 + k)));
        step("sim_wp", 1'b0, bit_of(5), bit_of(5), put(5, 16'hBEEF));
        chk("sim_count", 32'(count[5*CW +: CW]), 8);
        chk("sim_ovf", 32'(ovf[5]), 0);
        for (int k = 0; k < 8; k++) begin
            exp_v = (k == 7) ? 16'hBEEF : WIDTH'(16'h51 + k);
            chk("sim_drain", 32'(D_pop[5*WIDTH +: WIDTH]), 32'(exp_v));
            step("sim_pop", 1'b0, '0, bit_of(5), '0);
        end

        // Underflow on channel 7 with a concurrent write
        step("udf_wp", 1'b0, bit_of(7), bit_of(7), put(7, 16'h1234));
        chk("udf_flag", 32'(udf[7]), 1);
        chk("udf_count", 32'(count[7*CW +: CW]), 1);
        chk("udf_dpop", 32'(D_pop[7*WIDTH +: WIDTH]), 32'h1234);
        step("udf_pop", 1'b0, '0, bit_of(7), '0);

        // Wrap-around on channel 2, then reset with 3 entries pending
        for (int t = 0; t < 20; t++) begin
            if (t >= 3) chk("wrap_head", 32'(D_pop[2*WIDTH +: WIDTH]), 32'h200 + 32'(t - 3));
            step("wrap", 1'b0, bit_of(2), (t >= 3) ? bit_of(2) : '0, put(2, WIDTH'(16'h200 + t)));
        end
        chk("wrap_pend", 32'(count[2*CW +: CW]), 3);
        step("wrap_rst", 1'b1, '0, '0, '0);
        chk("wrap_rcount", 32'(count[2*CW +: CW]), 0);
        chk("wrap_rpndng", 32'(pndng[2]), 0);
        step("wrap_wr", 1'b0, bit_of(2), '0, put(2, 16'h7777));
        chk("wrap_rdback", 32'(D_pop[2*WIDTH +: WIDTH]), 32'h7777);

        // Randomized traffic across all channels
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < DRVS; i++) rd[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            rw = DRVS'($urandom);
            rp = DRVS'($urandom) & DRVS'($urandom | ((n / 50) % 2 == 0 ? 0 : 32'hFF));
            step("rand", ($urandom_range(0, 63) == 0), rw, rp, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
